// File: rtl/dummy_mem.sv
// rtl/dummy_mem.sv - fixed-latency behavioural memory model with independent read and write ports
//
// Purpose:
//   Stands in for main memory beneath cache/pipeline blocks. Each port accepts a
//   level-sensitive request while idle, waits a fixed number of clock edges, then
//   completes with a one-cycle finished pulse. Words never written read as zero.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   d_out       read data, registered, held until the next read completion
//   d_in        write data, sampled when a write is accepted
//   re          read request (level)
//   we          write request (level)
//   r_addr      read byte address, sampled when a read is accepted
//   w_addr      write byte address, sampled when a write is accepted
//   r_finished  one-cycle pulse, d_out valid for the completed read
//   w_finished  one-cycle pulse, write committed to the array

module dummy_mem #(
    parameter int READ_LATENCY  = 10,
    parameter int WRITE_LATENCY = 10,
    parameter int ADDR_BITS     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] d_out,
    input  logic [31:0] d_in,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] r_addr,
    input  logic [31:0] w_addr,
    output logic        r_finished,
    output logic        w_finished
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int RCW   = $clog2(READ_LATENCY + 1);
    localparam int WCW   = $clog2(WRITE_LATENCY + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Read engine state
    state_t                 r_state_q, r_state_d;
    logic [RCW-1:0]         r_cnt_q, r_cnt_d;
    logic [ADDR_BITS-1:0]   r_idx_q, r_idx_d;

    // Write engine state
    state_t                 w_state_q, w_state_d;
    logic [WCW-1:0]         w_cnt_q, w_cnt_d;
    logic [ADDR_BITS-1:0]   w_idx_q, w_idx_d;
    logic [31:0]            w_data_q, w_data_d;

    // Storage: data array is never reset, validity is tracked per word
    logic [31:0]            mem [DEPTH];
    logic [DEPTH-1:0]       valid_q, valid_d;

    // Registered outputs
    logic [31:0]            d_out_q, d_out_d;
    logic                   r_finished_q, r_finished_d;
    logic                   w_finished_q, w_finished_d;

    logic                   r_done;
    logic                   w_done;
    logic [31:0]            rd_word;

    // Only the word-index slice of each address matters; the rest aliases.
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^{r_addr[31:ADDR_BITS+2], r_addr[1:0],
                                w_addr[31:ADDR_BITS+2], w_addr[1:0]};

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q    <= IDLE;
            r_cnt_q      <= '0;
            r_idx_q      <= '0;
            w_state_q    <= IDLE;
            w_cnt_q      <= '0;
            w_idx_q      <= '0;
            w_data_q     <= '0;
            valid_q      <= '0;
            d_out_q      <= '0;
            r_finished_q <= 1'b0;
            w_finished_q <= 1'b0;
        end else begin
            r_state_q    <= r_state_d;
            r_cnt_q      <= r_cnt_d;
            r_idx_q      <= r_idx_d;
            w_state_q    <= w_state_d;
            w_cnt_q      <= w_cnt_d;
            w_idx_q      <= w_idx_d;
            w_data_q     <= w_data_d;
            valid_q      <= valid_d;
            d_out_q      <= d_out_d;
            r_finished_q <= r_finished_d;
            w_finished_q <= w_finished_d;
        end
    end

    // The write enable is derived from reset-cleared engine state, so an
    // aborted write can never reach the array.
    always_ff @(posedge clk) begin
        if (w_done) begin
            mem[w_idx_q] <= w_data_q;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Counter is loaded with LATENCY-1 at acceptance; completion happens on the
    // edge where the counter is already zero, i.e. LATENCY edges after acceptance.
    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_idx_d   = r_idx_q;
        if (r_state_q == IDLE) begin
            if (re) begin
                r_state_d = BUSY;
                r_cnt_d   = RCW'(READ_LATENCY - 1);
                r_idx_d   = r_addr[ADDR_BITS+1:2];
            end
        end else begin
            if (r_cnt_q == '0) begin
                r_state_d = IDLE;
            end else begin
                r_cnt_d = r_cnt_q - RCW'(1);
            end
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        w_idx_d   = w_idx_q;
        w_data_d  = w_data_q;
        if (w_state_q == IDLE) begin
            if (we) begin
                w_state_d = BUSY;
                w_cnt_d   = WCW'(WRITE_LATENCY - 1);
                w_idx_d   = w_addr[ADDR_BITS+1:2];
                w_data_d  = d_in;
            end
        end else begin
            if (w_cnt_q == '0) begin
                w_state_d = IDLE;
            end else begin
                w_cnt_d = w_cnt_q - WCW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output / storage-update logic
    // ------------------------------------------------------------------
    always_comb begin
        r_done = (r_state_q == BUSY) && (r_cnt_q == '0);
        w_done = (w_state_q == BUSY) && (w_cnt_q == '0);

        // Write-first bypass when both engines complete on the same word.
        if (w_done && (w_idx_q == r_idx_q)) begin
            rd_word = w_data_q;
        end else if (valid_q[r_idx_q]) begin
            rd_word = mem[r_idx_q];
        end else begin
            rd_word = 32'h0;
        end

        d_out_d      = r_done ? rd_word : d_out_q;
        r_finished_d = r_done;
        w_finished_d = w_done;

        valid_d = valid_q;
        if (w_done) begin
            valid_d[w_idx_q] = 1'b1;
        end
    end

    assign d_out      = d_out_q;
    assign r_finished = r_finished_q;
    assign w_finished = w_finished_q;

endmodule

// File: tb/tb_dummy_mem.sv
// tb/tb_dummy_mem.sv - directed self-checking bench for dummy_mem

module tb_dummy_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] d_out;
    logic [31:0] d_in = '0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [31:0] r_addr = '0;
    logic [31:0] w_addr = '0;
    logic        r_finished;
    logic        w_finished;

    int vectors = 0;
    int miscompares = 0;

    dummy_mem dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_out      (d_out),
        .d_in       (d_in),
        .re         (re),
        .we         (we),
        .r_addr     (r_addr),
        .w_addr     (w_addr),
        .r_finished (r_finished),
        .w_finished (w_finished)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then settled for that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a single read, return positioned one edge before its completion.
    task automatic issue_read(input logic [31:0] addr);
        re = 1'b1;
        r_addr = addr;
        step();
        re = 1'b0;
        repeat (9) step();
    endtask

    // Issue a single write, return positioned one edge before its completion.
    task automatic issue_write(input logic [31:0] addr, input logic [31:0] data);
        we = 1'b1;
        w_addr = addr;
        d_in = data;
        step();
        we = 1'b0;
        repeat (9) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if ({d_out, r_finished, w_finished} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got d_out=%h rf=%b wf=%b, want 0 0 0", d_out, r_finished, w_finished);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            vectors++;
            if ({d_out, r_finished, w_finished} !== 34'h0) begin
                miscompares++;
                $display("FAIL idle_cycle%0d: got d_out=%h rf=%b wf=%b, want 0 0 0", i, d_out, r_finished, w_finished);
            end
        end
    endtask

    task automatic test_read_unwritten();
        // Populate index 0x3FF so that a wrongly followed address change shows up.
        issue_write(32'hFFFF_FFFF, 32'h55AA_55AA);
        step();
        vectors++;
        if (w_finished !== 1'b1) begin
            miscompares++;
            $display("FAIL preload_wfin: got %b want 1", w_finished);
        end
        step();
        re = 1'b1;
        r_addr = 32'hABCD_ABCD;
        step();
        re = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 2) r_addr = 32'hFFFF_FFFF;
            vectors++;
            if (r_finished !== (k == 10)) begin
                miscompares++;
                $display("FAIL unwritten_rfin_k%0d: got %b want %b", k, r_finished, (k == 10));
            end
            if (k == 10) begin
                vectors++;
                if (d_out !== 32'h0) begin
                    miscompares++;
                    $display("FAIL unwritten_data: got %h want 00000000", d_out);
                end
            end
        end
    endtask

    task automatic test_write_then_read();
        we = 1'b1;
        w_addr = 32'h0000_0010;
        d_in = 32'hDEAD_BEEF;
        step();
        we = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            vectors++;
            if (w_finished !== (k == 10)) begin
                miscompares++;
                $display("FAIL wr_wfin_k%0d: got %b want %b", k, w_finished, (k == 10));
            end
        end
        issue_read(32'h0000_1010);
        step();
        vectors++;
        if (r_finished !== 1'b1 || d_out !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL alias_read: got rf=%b d_out=%h want 1 deadbeef", r_finished, d_out);
        end
        repeat (5) step();
        vectors++;
        if (r_finished !== 1'b0 || d_out !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL d_out_hold: got rf=%b d_out=%h want 0 deadbeef", r_finished, d_out);
        end
    endtask

    task automatic test_back_to_back();
        re = 1'b1;
        we = 1'b1;
        r_addr = 32'h0000_0020;
        w_addr = 32'h0000_0020;
        d_in = 32'h1111_2222;
        for (int k = 0; k <= 34; k++) begin
            step();
            vectors++;
            if (r_finished !== (k == 10 || k == 21 || k == 32) ||
                w_finished !== (k == 10 || k == 21 || k == 32)) begin
                miscompares++;
                $display("FAIL b2b_edge%0d: got rf=%b wf=%b want %b", k, r_finished, w_finished,
                         (k == 10 || k == 21 || k == 32));
            end
            if (k == 10) begin
                vectors++;
                if (d_out !== 32'h1111_2222) begin
                    miscompares++;
                    $display("FAIL b2b_bypass: got %h want 11112222", d_out);
                end
            end
        end
        re = 1'b0;
        we = 1'b0;
        repeat (12) step();
    endtask

    task automatic test_collision();
        re = 1'b1;
        we = 1'b1;
        r_addr = 32'h0000_001C;
        w_addr = 32'h0000_001C;
        d_in = 32'h1234_5678;
        step();
        re = 1'b0;
        we = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step();
            vectors++;
            if (r_finished !== (k == 10) || w_finished !== (k == 10)) begin
                miscompares++;
                $display("FAIL coll_k%0d: got rf=%b wf=%b want %b", k, r_finished, w_finished, (k == 10));
            end
            if (k == 10) begin
                vectors++;
                if (d_out !== 32'h1234_5678) begin
                    miscompares++;
                    $display("FAIL coll_data: got %h want 12345678", d_out);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        we = 1'b1;
        w_addr = 32'h0000_000C;
        d_in = 32'hCAFE_F00D;
        step();
        we = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({d_out, r_finished, w_finished} !== 34'h0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got d_out=%h rf=%b wf=%b want 0 0 0", d_out, r_finished, w_finished);
        end
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            vectors++;
            if (w_finished !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_wfin_k%0d: got %b want 0", k, w_finished);
            end
        end
        // Make d_out non-zero so the zero reads that follow are meaningful.
        issue_write(32'h0000_0014, 32'h0BAD_CAFE);
        step();
        step();
        issue_read(32'h0000_0014);
        step();
        vectors++;
        if (r_finished !== 1'b1 || d_out !== 32'h0BAD_CAFE) begin
            miscompares++;
            $display("FAIL post_rst_read5: got rf=%b d_out=%h want 1 0badcafe", r_finished, d_out);
        end
        step();
        issue_read(32'h0000_000C);
        step();
        vectors++;
        if (r_finished !== 1'b1 || d_out !== 32'h0) begin
            miscompares++;
            $display("FAIL aborted_write_read3: got rf=%b d_out=%h want 1 00000000", r_finished, d_out);
        end
        step();
        issue_read(32'h0000_0014);
        step();
        step();
        issue_read(32'h0000_0010);
        step();
        vectors++;
        if (r_finished !== 1'b1 || d_out !== 32'h0) begin
            miscompares++;
            $display("FAIL valid_cleared_read4: got rf=%b d_out=%h want 1 00000000", r_finished, d_out);
        end
    endtask

    initial begin
        test_reset();
        test_read_unwritten();
        test_write_then_read();
        test_back_to_back();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dummy_mem.md
Name: dummy_mem

Overview:
- Behavioural-timing memory model with one 32-bit read port and one 32-bit write port. Each port runs its own fixed-latency request/finish handshake.
- Stands in for main memory under cache/pipeline blocks, so that multi-cycle memory stalls can be exercised.
- Word-addressed internal storage; reads of never-written words return zero.

Parameters:
- READ_LATENCY, 10, clock edges from read-request acceptance to r_finished assertion (>=1)
- WRITE_LATENCY, 10, clock edges from write-request acceptance to w_finished assertion / array commit (>=1)
- ADDR_BITS, 10, log2 of word count; storage = 2^ADDR_BITS x 32 bits

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- d_out  output  32  read data, registered, held between reads
- d_in  input  32  write data, sampled at write acceptance
- re  input  1  read request, level-sensitive
- we  input  1  write request, level-sensitive
- r_addr  input  32  read byte address, sampled at read acceptance
- w_addr  input  32  write byte address, sampled at write acceptance
- r_finished  output  1  one-cycle pulse: d_out valid for the current read
- w_finished  output  1  one-cycle pulse: write committed

Behaviour:
- Word index = addr[ADDR_BITS+1:2]. addr[1:0] and all higher bits are ignored, so addresses alias. Example: 0xABCDABCD -> index 0x2F3; 0xFFFFFFFF -> index 0x3FF.
- Each word has a valid bit. Reading a word whose valid bit is clear returns 32'h0.
- Reset (rst_n low, asynchronous):
  - d_out=0, r_finished=0, w_finished=0.
  - Both engines go IDLE and counters clear.
  - All valid bits clear. Data array contents are don't-care.
  - Any in-flight request is aborted; its write does not commit and no finished pulse is produced.
- Read engine, states IDLE and BUSY:
  - IDLE, re=1 at a rising edge N: latch word index, load counter, go BUSY. r_addr changes after edge N have no effect.
  - BUSY: at edge N+READ_LATENCY, d_out <= word (or 0 if invalid), r_finished <= 1, go IDLE.
  - r_finished is high for exactly one cycle (edge N+READ_LATENCY to edge N+READ_LATENCY+1).
  - The next acceptance is at the earliest edge N+READ_LATENCY+1 if re is still 1. A held re therefore yields one read every READ_LATENCY+1 cycles.
  - re deasserted while BUSY does not cancel the read.
- Write engine, identical structure:
  - IDLE, we=1 at edge M: latch index and d_in.
  - At edge M+WRITE_LATENCY: write array, set valid bit, pulse w_finished for one cycle, go IDLE.
- The two engines are fully independent and may be busy concurrently.
- Read and write completing at the same edge on the same index: read returns the newly written data (write-first bypass).
- A read completing after a write to the same index has committed returns the written data. A read completing before that commit returns the old data (or 0).
- d_out holds its value until the next read completion or reset.
- Outputs are registered only; there are no combinational input-to-output paths.

Test Plan:
- Reset then idle: rst_n low -> d_out=0, r_finished=0, w_finished=0. Hold re=we=0 for 50 cycles -> outputs unchanged.
- Read of unwritten word: re=1 with r_addr=0xABCDABCD at edge N, then change r_addr to 0xFFFFFFFF 2 cycles later -> r_finished pulses 1 cycle at edge N+10, d_out=0. The address change is ignored.
- Write then read: we=1, w_addr=0x00000010, d_in=0xDEADBEEF -> w_finished pulses at M+10. Then read r_addr=0x00001010 (aliases to index 4) -> d_out=0xDEADBEEF after 10 cycles.
- Held re and we from edge 0 -> r_finished and w_finished each pulse at edges 10, 21, 32. Each pulse is exactly one cycle wide.
- Same-edge collision: start a write of 0x12345678 and a read to index 7 on the same edge -> both finish at edge +10 and d_out=0x12345678.
- Reset mid-operation: assert rst_n low 5 cycles into a write of 0xCAFEF00D to index 3 -> no w_finished. A subsequent read of index 3 returns 0.
